// File: rtl/div_sequencer.sv
// Issue/retire controller in front of the free-running radix-2 divider. It resolves
// RISC-V divide special cases locally and holds the divider operands for the whole op.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic [1:0]       operation_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  output logic [1:0]       div_op_o,
  input  logic             div_fu_state_i,
  input  logic [XLEN-1:0]  div_result_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             zero_div_o
);

  typedef enum logic [1:0] {DIV_ = 2'd0, DIVU_ = 2'd1, REM_ = 2'd2, REMU_ = 2'd3} div_ops_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_CAPTURE, ST_DONE, ST_DRAIN} state_e;

  localparam logic            FU_FREE = 1'b0;
  localparam logic            FU_BUSY = 1'b1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  div_ops_e        op_in;
  logic            is_signed;
  logic            is_rem;
  logic            div_by_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;

  // Special-case decode of the op currently offered by the issue stage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    op_in          = div_ops_e'(operation_i);
    is_signed      = (op_in == DIV_) || (op_in == REM_);
    is_rem         = (op_in == REM_) || (op_in == REMU_);
    div_by_zero    = (divisor_i == '0);
    sgn_ovf        = is_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
    special        = div_by_zero || sgn_ovf;
    special_result = '0;
    if (div_by_zero) begin
      special_result = is_rem ? dividend_i : '1;
    end else if (sgn_ovf) begin
      special_result = is_rem ? '0 : INT_MIN;
    end
  end

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      ready_o        <= 1'b1;
      valid_o        <= 1'b0;
      result_o       <= '0;
      tag_o          <= '0;
      zero_div_o     <= 1'b0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_op_o       <= '0;
    end else if (clk_en_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (valid_i && !flush_i) begin
            tag_o   <= tag_i;
            ready_o <= 1'b0;
            if (special) begin
              result_o   <= special_result;
              zero_div_o <= div_by_zero;
              valid_o    <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              div_dividend_o <= dividend_i;
              div_divisor_o  <= divisor_i;
              div_op_o       <= operation_i;
              zero_div_o     <= 1'b0;
              state_q        <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          if (flush_i) begin
            ready_o <= 1'b1;
            state_q <= ST_IDLE;
          end else if (div_fu_state_i == FU_FREE) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            state_q <= ST_DRAIN;
          end else if (div_fu_state_i == FU_BUSY) begin
            state_q <= ST_CAPTURE;
          end
        end
        // The divider result is valid in its first FREE cycle after BUSY.
        ST_CAPTURE: begin
          if (flush_i) begin
            state_q <= ST_DRAIN;
          end else if (div_fu_state_i == FU_FREE) begin
            result_o <= div_result_i;
            valid_o  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush_i || ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (div_fu_state_i == FU_FREE) begin
            ready_o <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a cycle-level model of the free-running
// divider (1 FREE cycle, 33 BUSY cycles, result depends on the held operands).
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i, clk_en_i, flush_i, valid_i, ready_o, ready_i;
  logic [31:0] dividend_i, divisor_i, div_dividend_o, div_divisor_o, div_result_i, result_o;
  logic [1:0]  operation_i, div_op_o;
  logic [4:0]  tag_i, tag_o;
  logic        div_fu_state_i, valid_o, zero_div_o;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  div_sequencer #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .operation_i(operation_i), .tag_i(tag_i), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_op_o(div_op_o), .div_fu_state_i(div_fu_state_i),
    .div_result_i(div_result_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .tag_o(tag_o), .zero_div_o(zero_div_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] q;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      OP_DIV:  q = $signed(a) / $signed(b);
      OP_REM:  q = $signed(a) % $signed(b);
      OP_DIVU: q = a / b;
      default: q = a % b;
    endcase
    return q;
  endfunction

  // Divider model: latches operands in its FREE cycle, then BUSY for 33 cycles.
  int unsigned dv_cnt;
  logic [31:0] lat_a, lat_b;
  logic [1:0]  lat_op;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dv_cnt <= 0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
    end else if (clk_en_i) begin
      if (dv_cnt == 0) begin
        lat_a  <= div_dividend_o;
        lat_b  <= div_divisor_o;
        lat_op <= div_op_o;
      end
      dv_cnt <= (dv_cnt == 33) ? 0 : dv_cnt + 1;
    end
  end
  assign div_fu_state_i = (dv_cnt != 0);
  assign div_result_i = (dv_cnt == 0 && div_dividend_o == lat_a && div_divisor_o == lat_b &&
                         div_op_o == lat_op) ? ref_div(lat_op, lat_a, lat_b) : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic align(input int unsigned phase);
    int guard = 0;
    while (dv_cnt != phase && guard < 40) begin step(); guard++; end
  endtask

  // Offers one op and returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp_res, input logic exp_zero);
    int guard = 0;
    valid_i = 1'b1; operation_i = op; dividend_i = a; divisor_i = b; tag_i = tag;
    while (!(ready_o && clk_en_i) && guard < 200) begin step(); guard++; end
    n_assert++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL accept_timeout: ready_o=%b required 1", ready_o);
    end else begin
      sb.push_back('{exp_res, tag, exp_zero});
    end
    step();
    valid_i = 1'b0;
  endtask

  task automatic drop();
    exp_t d;
    if (sb.size() != 0) d = sb.pop_front();
  endtask

  // Waits for valid_o; lat counts cycles from the accept cycle (accept cycle = 0).
  task automatic wait_valid(input string name, input int start_lat, input int exp_lat);
    int   lat = start_lat;
    logic ready_seen = 1'b0;
    while (!valid_o && lat < 200) begin
      if (ready_o) ready_seen = 1'b1;
      step();
      lat++;
    end
    n_assert++;
    if (!valid_o) begin
      n_fail++;
      $display("FAIL %s_valid_timeout: valid_o=%b required 1", name, valid_o);
      return;
    end
    if (exp_lat > 0) begin
      n_assert++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, exp_lat);
      end
    end
    n_assert++;
    if (ready_seen || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ready_busy: ready_o went 1 while op in flight, required 0", name);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: unexpected result %h", name, result_o);
      return;
    end
    e = sb.pop_front();
    if (result_o !== e.result) begin
      n_fail++;
      $display("FAIL %s_result: result_o=%h required %h", name, result_o, e.result);
    end
    n_assert++;
    if (tag_o !== e.tag) begin
      n_fail++;
      $display("FAIL %s_tag: tag_o=%0d required %0d", name, tag_o, e.tag);
    end
    n_assert++;
    if (zero_div_o !== e.zero) begin
      n_fail++;
      $display("FAIL %s_zero_div: zero_div_o=%b required %b", name, zero_div_o, e.zero);
    end
  endtask

  task automatic release_result(input string name);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    n_assert++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_retire: valid_o=%b ready_o=%b required 0/1", name, valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    n_assert++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0 || tag_o !== 5'd0 ||
        zero_div_o !== 1'b0 || div_dividend_o !== 32'd0 || div_divisor_o !== 32'd0 ||
        div_op_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b res=%h tag=%0d zd=%b div=%h/%h/%0d required 1/0/0/0/0/0/0/0",
               ready_o, valid_o, result_o, tag_o, zero_div_o, div_dividend_o, div_divisor_o, div_op_o);
    end
  endtask

  task automatic test_divu_aligned();
    align(33);
    send(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);
    n_assert++;
    if (div_dividend_o !== 32'd100 || div_divisor_o !== 32'd7 || div_op_o !== OP_DIVU) begin
      n_fail++;
      $display("FAIL divu_launch_operands: %h/%h/%0d required 00000064/00000007/1",
               div_dividend_o, div_divisor_o, div_op_o);
    end
    wait_valid("divu_aligned", 1, 36);
    check_result("divu_aligned");
    release_result("divu_aligned");
  endtask

  task automatic test_rem_hold();
    send(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 1'b0);
    wait_valid("rem_neg", 1, 0);
    check_result("rem_neg");
    for (int i = 0; i < 5; i++) begin
      step();
      n_assert++;
      if (valid_o !== 1'b1 || result_o !== 32'hFFFF_FFFF || tag_o !== 5'd9 || zero_div_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rem_hold_%0d: valid=%b res=%h tag=%0d zd=%b required 1/ffffffff/9/0",
                 i, valid_o, result_o, tag_o, zero_div_o);
      end
    end
    release_result("rem_hold");
  endtask

  task automatic test_div_zero();
    logic [1:0]  ops[4]  = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    logic [31:0] dvd[4]  = '{32'd5, 32'd5, 32'd5, 32'd9};
    logic [31:0] exp[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd9};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], dvd[i], 32'd0, 5'(i + 20), exp[i], 1'b1);
      wait_valid("div_zero", 1, 1);
      check_result("div_zero");
      n_assert++;
      if (div_dividend_o !== 32'hFFFF_FFF9 || div_divisor_o !== 32'd2) begin
        n_fail++;
        $display("FAIL div_zero_no_launch_%0d: div operands %h/%h required fffffff9/00000002",
                 i, div_dividend_o, div_divisor_o);
      end
      release_result("div_zero");
    end
  endtask

  task automatic test_overflow();
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1'b0);
    wait_valid("ovf_div", 1, 1);
    check_result("ovf_div");
    release_result("ovf_div");
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'd0, 1'b0);
    wait_valid("ovf_rem", 1, 1);
    check_result("ovf_rem");
    release_result("ovf_rem");
    send(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 1'b0);
    wait_valid("ovf_divu", 1, 0);
    check_result("ovf_divu");
    release_result("ovf_divu");
  endtask

  task automatic test_worst_latency();
    align(0);
    send(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFF2, 1'b0);
    wait_valid("worst", 1, 69);
    check_result("worst");
    release_result("worst");
  endtask

  task automatic test_flush_wait();
    int   guard = 0;
    logic seen_valid = 1'b0;
    align(33);
    send(OP_DIVU, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b0);
    drop();
    for (int i = 0; i < 10; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    while (!ready_o && guard < 60) begin
      if (valid_o) seen_valid = 1'b1;
      step();
      guard++;
    end
    n_assert++;
    if (seen_valid || valid_o) begin
      n_fail++;
      $display("FAIL flush_wait_no_valid: valid_o seen 1 required 0");
    end
    n_assert++;
    if (ready_o !== 1'b1 || dv_cnt != 1) begin
      n_fail++;
      $display("FAIL flush_wait_drain: ready_o=%b divider phase %0d required 1 at phase 1", ready_o, dv_cnt);
    end
    send(OP_DIVU, 32'd77, 32'd7, 5'd12, 32'd11, 1'b0);
    wait_valid("after_flush", 1, 0);
    check_result("after_flush");
    release_result("after_flush");
  endtask

  task automatic test_flush_launch_done();
    logic seen_valid = 1'b0;
    align(0);
    send(OP_DIVU, 32'd50, 32'd5, 5'd8, 32'd10, 1'b0);
    drop();
    step(); step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_assert++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_launch: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seen_valid = 1'b1;
      step();
    end
    n_assert++;
    if (seen_valid) begin
      n_fail++;
      $display("FAIL flush_launch_late_valid: valid_o seen 1 required 0");
    end
    send(OP_DIV, 32'd5, 32'd0, 5'd1, 32'hFFFF_FFFF, 1'b1);
    drop();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_assert++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_clk_en();
    align(33);
    send(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
    for (int i = 0; i < 4; i++) step();
    clk_en_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    clk_en_i = 1'b1;
    wait_valid("clk_en", 8, 39);
    check_result("clk_en");
    release_result("clk_en");
    clk_en_i = 1'b0;
    valid_i = 1'b1; operation_i = OP_DIV; dividend_i = 32'd5; divisor_i = 32'd0; tag_i = 5'd2;
    step(); step();
    valid_i = 1'b0;
    clk_en_i = 1'b1;
    n_assert++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd14) begin
      n_fail++;
      $display("FAIL clk_en_special_frozen: valid=%b ready=%b res=%h required 0/1/0000000e",
               valid_o, ready_o, result_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(OP_REMU, 32'(i * 3 + 1), 32'd0, 5'(i), 32'(i * 3 + 1), 1'b1);
      wait_valid("b2b", 1, 1);
      check_result("b2b");
    end
    step();
    ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(OP_DIVU, 32'd900, 32'd3, 5'd30, 32'd300, 1'b0);
    drop();
    for (int i = 0; i < 5; i++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_assert++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || div_dividend_o !== 32'd0 || tag_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b valid=%b div_dividend=%h tag=%0d required 1/0/0/0",
               ready_o, valid_o, div_dividend_o, tag_o);
    end
    send(OP_REMU, 32'd17, 32'd5, 5'd31, 32'd2, 1'b0);
    wait_valid("after_reset", 1, 0);
    check_result("after_reset");
    release_result("after_reset");
  endtask

  initial begin
    rst_i = 1'b1; clk_en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    dividend_i = '0; divisor_i = '0; operation_i = '0; tag_i = '0;
    test_reset();
    test_divu_aligned();
    test_rem_hold();
    test_div_zero();
    test_overflow();
    test_worst_latency();
    test_flush_wait();
    test_flush_launch_done();
    test_clk_en();
    test_back_to_back();
    test_reset_mid();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
